// File: rtl/mpeg_pkg.sv
// Shared types and constants for the MPEG bit-extraction front end.
package mpeg_pkg;

    localparam int WORD_W  = 32;
    localparam int MAX_GET = 32;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RESP,
        ST_CONSUME,
        ST_WAIT_LOAD,
        ST_WAIT_FILL
    } state_t;

    // Requests above MAX_GET are treated as a full-window read.
    function automatic logic [5:0] clamp_n(input logic [5:0] n);
        return (n > 6'(MAX_GET)) ? 6'(MAX_GET) : n;
    endfunction

endpackage

// File: rtl/mpeg_getbits_if.sv
// Client request/response channel of mpeg_getbits (show_bits / get_bits).
interface mpeg_getbits_if;
    import mpeg_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [5:0]        req_n;
    logic              req_peek;
    logic              rsp_valid;
    logic [WORD_W-1:0] rsp_bits;

    modport master (
        output req_valid, req_n, req_peek,
        input  req_ready, rsp_valid, rsp_bits
    );

    modport slave (
        input  req_valid, req_n, req_peek,
        output req_ready, rsp_valid, rsp_bits
    );

endinterface

// File: rtl/mpeg_showbits.sv
// Combinational extractor: top n bits of a left-aligned window, right-aligned.
module mpeg_showbits
    import mpeg_pkg::*;
(
    input  logic [WORD_W-1:0] ld_bfr,
    input  logic [5:0]        n,
    output logic [WORD_W-1:0] bits
);

    logic [5:0] sh;

    // n = 0 yields a shift of 32, which empties the word.
    assign sh   = 6'(WORD_W) - n;
    assign bits = ld_bfr >> sh;

endmodule

// File: rtl/mpeg_getbits.sv
// Serves show/get bit requests from flushbuffer's window, issues flushes
// for consumed bits, and tracks the consumed-bit position.
module mpeg_getbits
    import mpeg_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int POS_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    mpeg_getbits_if.slave     cl,
    output logic              flush_valid,
    output logic [WORD_W-1:0] flush_n,
    input  logic              flush_loading,
    input  logic [WORD_W-1:0] ld_bfr,
    output logic [POS_W-1:0]  bitpos,
    output logic              err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t            state;
    logic [TW-1:0]     tmr;
    logic [5:0]        n_q;
    logic [5:0]        n_eff;
    logic              n_bad;
    logic [WORD_W-1:0] shown;
    logic              tmr_done;

    assign n_eff    = clamp_n(cl.req_n);
    assign n_bad    = (cl.req_n > 6'(MAX_GET));
    assign tmr_done = (tmr == TW'(TIMEOUT - 1));

    mpeg_showbits u_showbits (
        .ld_bfr (ld_bfr),
        .n      (n_eff),
        .bits   (shown)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_INIT;
            tmr          <= '0;
            n_q          <= '0;
            cl.req_ready <= 1'b0;
            cl.rsp_valid <= 1'b0;
            cl.rsp_bits  <= '0;
            flush_valid  <= 1'b0;
            flush_n      <= '0;
            bitpos       <= '0;
            err          <= 1'b0;
        end else begin
            cl.rsp_valid <= 1'b0;
            flush_valid  <= 1'b0;
            case (state)
                ST_INIT: begin
                    flush_valid <= 1'b1;
                    flush_n     <= '0;
                    tmr         <= '0;
                    state       <= ST_WAIT_LOAD;
                end
                ST_IDLE: begin
                    if (cl.req_valid) begin
                        cl.req_ready <= 1'b0;
                        cl.rsp_valid <= 1'b1;
                        cl.rsp_bits  <= shown;
                        n_q          <= n_eff;
                        if (n_bad)
                            err <= 1'b1;
                        if (cl.req_peek || n_eff == 6'd0) begin
                            state <= ST_RESP;
                        end else begin
                            flush_valid <= 1'b1;
                            flush_n     <= WORD_W'(n_eff);
                            state       <= ST_CONSUME;
                        end
                    end
                end
                ST_RESP: begin
                    cl.req_ready <= 1'b1;
                    state        <= ST_IDLE;
                end
                ST_CONSUME: begin
                    bitpos <= bitpos + POS_W'(n_q);
                    tmr    <= '0;
                    state  <= ST_WAIT_LOAD;
                end
                ST_WAIT_LOAD: begin
                    if (flush_loading) begin
                        tmr   <= '0;
                        state <= ST_WAIT_FILL;
                    end else if (tmr_done) begin
                        err          <= 1'b1;
                        cl.req_ready <= 1'b1;
                        state        <= ST_IDLE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                ST_WAIT_FILL: begin
                    if (!flush_loading || tmr_done) begin
                        if (flush_loading)
                            err <= 1'b1;
                        cl.req_ready <= 1'b1;
                        state        <= ST_IDLE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_mpeg_getbits.sv
// Directed bench for mpeg_getbits with a simple flushbuffer loading model.
module tb_mpeg_getbits;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_valid;
    logic [31:0] flush_n;
    logic        flush_loading;
    logic [31:0] ld_bfr;
    logic [31:0] bitpos;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;
    bit fb_en = 1'b1;
    int ld_cnt = 0;

    always #5 clk = ~clk;

    mpeg_getbits_if bus ();

    mpeg_getbits #(.TIMEOUT(TO), .POS_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .cl            (bus.slave),
        .flush_valid   (flush_valid),
        .flush_n       (flush_n),
        .flush_loading (flush_loading),
        .ld_bfr        (ld_bfr),
        .bitpos        (bitpos),
        .err           (err)
    );

    // Flushbuffer stand-in: loading rises the edge after a flush, stays high 3 cycles.
    initial flush_loading = 1'b0;
    always @(posedge clk) begin
        if (fb_en && flush_valid) begin
            flush_loading <= 1'b1;
            ld_cnt        <= 3;
        end else if (ld_cnt == 1) begin
            flush_loading <= 1'b0;
            ld_cnt        <= 0;
        end else if (ld_cnt > 1) begin
            ld_cnt <= ld_cnt - 1;
        end
    end

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 50 && !bus.req_ready; i++) @(negedge clk);
        if (!bus.req_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: req_ready never rose within 50 cycles", tag);
        end
    endtask

    // Returns at the negedge right after the accepting posedge.
    task automatic do_req(input logic [5:0] n, input logic peek);
        wait_ready("do_req");
        bus.req_valid = 1'b1;
        bus.req_n     = n;
        bus.req_peek  = peek;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.req_ready, bus.rsp_valid, flush_valid, err} !== 4'b0000 ||
            bus.rsp_bits !== 32'h0 || flush_n !== 32'h0 || bitpos !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: rdy=%b rv=%b fv=%b err=%b bits=%h fn=%0d pos=%0d, required all 0",
                     bus.req_ready, bus.rsp_valid, flush_valid, err, bus.rsp_bits, flush_n, bitpos);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (flush_valid !== 1'b1 || flush_n !== 32'd0) begin
            n_bad++;
            $display("FAIL prime_flush: fv=%b fn=%0d, required fv=1 fn=0", flush_valid, flush_n);
        end
        @(negedge clk);
        n_cmp++;
        if (flush_valid !== 1'b0 || flush_loading !== 1'b1) begin
            n_bad++;
            $display("FAIL prime_pulse_width: fv=%b loading=%b, required fv=0 loading=1",
                     flush_valid, flush_loading);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 1'b0 || flush_loading !== 1'b0) begin
            n_bad++;
            $display("FAIL prime_ready_early: rdy=%b loading=%b, required rdy=0 loading=0",
                     bus.req_ready, flush_loading);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 1'b1 || bitpos !== 32'd0) begin
            n_bad++;
            $display("FAIL prime_ready: rdy=%b pos=%0d, required rdy=1 pos=0", bus.req_ready, bitpos);
        end
    endtask

    task automatic test_get32();
        ld_bfr = 32'h0000_01B3;
        do_req(6'd32, 1'b0);
        n_cmp++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_bits !== 32'h0000_01B3 ||
            flush_valid !== 1'b1 || flush_n !== 32'd32 || bus.req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL get32_rsp: rv=%b bits=%h fv=%b fn=%0d rdy=%b, required 1 000001b3 1 32 0",
                     bus.rsp_valid, bus.rsp_bits, flush_valid, flush_n, bus.req_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.rsp_valid !== 1'b0 || flush_valid !== 1'b0 || bitpos !== 32'd32) begin
            n_bad++;
            $display("FAIL get32_after: rv=%b fv=%b pos=%0d, required 0 0 32",
                     bus.rsp_valid, flush_valid, bitpos);
        end
        wait_ready("get32");
    endtask

    task automatic test_peek();
        ld_bfr = 32'h4700_0000;
        do_req(6'd8, 1'b1);
        n_cmp++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_bits !== 32'h0000_0047 ||
            flush_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL peek_rsp: rv=%b bits=%h fv=%b rdy=%b, required 1 00000047 0 0",
                     bus.rsp_valid, bus.rsp_bits, flush_valid, bus.req_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || flush_valid !== 1'b0 ||
            bitpos !== 32'd32 || flush_n !== 32'd32) begin
            n_bad++;
            $display("FAIL peek_after: rdy=%b rv=%b fv=%b pos=%0d fn=%0d, required 1 0 0 32 32",
                     bus.req_ready, bus.rsp_valid, flush_valid, bitpos, flush_n);
        end
    endtask

    task automatic test_get12_then_zero();
        ld_bfr = 32'hABCD_E000;
        do_req(6'd12, 1'b0);
        n_cmp++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_bits !== 32'h0000_0ABC ||
            flush_valid !== 1'b1 || flush_n !== 32'd12) begin
            n_bad++;
            $display("FAIL get12_rsp: rv=%b bits=%h fv=%b fn=%0d, required 1 00000abc 1 12",
                     bus.rsp_valid, bus.rsp_bits, flush_valid, flush_n);
        end
        @(negedge clk);
        n_cmp++;
        if (flush_valid !== 1'b0 || bitpos !== 32'd44) begin
            n_bad++;
            $display("FAIL get12_pulse: fv=%b pos=%0d, required 0 44", flush_valid, bitpos);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 1'b0 || flush_loading !== 1'b0) begin
            n_bad++;
            $display("FAIL get12_stall: rdy=%b loading=%b, required rdy=0 loading=0",
                     bus.req_ready, flush_loading);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL get12_ready: rdy=%b, required 1", bus.req_ready);
        end
        do_req(6'd0, 1'b0);
        n_cmp++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_bits !== 32'h0 || flush_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL get0_rsp: rv=%b bits=%h fv=%b, required 1 00000000 0",
                     bus.rsp_valid, bus.rsp_bits, flush_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 1'b1 || bitpos !== 32'd44 || flush_n !== 32'd12 || flush_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL get0_after: rdy=%b pos=%0d fn=%0d fv=%b, required 1 44 12 0",
                     bus.req_ready, bitpos, flush_n, flush_valid);
        end
    endtask

    task automatic test_illegal_n();
        ld_bfr = 32'h1234_5678;
        do_req(6'd40, 1'b0);
        n_cmp++;
        if (err !== 1'b1 || bus.rsp_bits !== 32'h1234_5678 || flush_n !== 32'd32 || flush_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL illegal_rsp: err=%b bits=%h fn=%0d fv=%b, required 1 12345678 32 1",
                     err, bus.rsp_bits, flush_n, flush_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (bitpos !== 32'd76) begin
            n_bad++;
            $display("FAIL illegal_pos: pos=%0d, required 76", bitpos);
        end
        wait_ready("illegal");
        n_cmp++;
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL illegal_sticky: err=%b, required 1", err);
        end
    endtask

    task automatic test_timeout();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_ready("timeout_prime");
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_pre_err: err=%b, required 0", err);
        end
        fb_en  = 1'b0;
        ld_bfr = 32'hF000_0000;
        do_req(6'd4, 1'b0);
        n_cmp++;
        if (bus.rsp_bits !== 32'h0000_000F || flush_n !== 32'd4) begin
            n_bad++;
            $display("FAIL timeout_rsp: bits=%h fn=%0d, required 0000000f 4", bus.rsp_bits, flush_n);
        end
        @(negedge clk);
        repeat (TO - 1) @(negedge clk);
        n_cmp++;
        if (err !== 1'b0 || bus.req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_early: err=%b rdy=%b, required 0 0", err, bus.req_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (err !== 1'b1 || bus.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_fire: err=%b rdy=%b, required 1 1", err, bus.req_ready);
        end
        fb_en = 1'b1;
    endtask

    task automatic test_reset_mid_fill();
        ld_bfr = 32'h8000_0000;
        do_req(6'd8, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.req_ready, bus.rsp_valid, flush_valid, err} !== 4'b0000 ||
            bus.rsp_bits !== 32'h0 || flush_n !== 32'h0 || bitpos !== 32'h0) begin
            n_bad++;
            $display("FAIL midfill_reset: rdy=%b rv=%b fv=%b err=%b bits=%h fn=%0d pos=%0d, required all 0",
                     bus.req_ready, bus.rsp_valid, flush_valid, err, bus.rsp_bits, flush_n, bitpos);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (flush_valid !== 1'b1 || flush_n !== 32'd0 || bus.rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midfill_reprime: fv=%b fn=%0d rv=%b, required 1 0 0",
                     flush_valid, flush_n, bus.rsp_valid);
        end
        wait_ready("midfill_reprime");
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_n     = 6'd0;
        bus.req_peek  = 1'b0;
        ld_bfr        = 32'h0;
        @(negedge clk);
        test_reset();
        test_get32();
        test_peek();
        test_get12_then_zero();
        test_illegal_n();
        test_timeout();
        test_reset_mid_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mpeg_getbits.md
Name: mpeg_getbits

Overview:
- Bit-extraction front end that sits directly downstream of flushbuffer in the MPEG decoder.
- Serves show/get requests of 1–32 bits from flushbuffer's left-aligned 32-bit window (ld_bfr).
- For consuming reads, it issues the N-bit flush to flushbuffer and stalls the client until the refill completes.
- It also primes the buffer after reset and keeps a running consumed-bit position for header and slice parsers.

Parameters:
- TIMEOUT, 64, max cycles to wait on each flushbuffer handshake phase before flagging an error.
- POS_W, 32, width of the consumed-bit position counter.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  client request strobe.
- req_ready  output  1  block can accept a request this cycle.
- req_n  input  6  bits requested; legal 1..32.
- req_peek  input  1  1 = show_bits (no consume), 0 = get_bits (consume).
- rsp_valid  output  1  one-cycle pulse, rsp_bits valid.
- rsp_bits  output  32  requested bits, right-aligned, upper bits zero.
- flush_valid  output  1  one-cycle pulse to flushbuffer in_valid.
- flush_n  output  32  flush count to flushbuffer N.
- flush_loading  input  1  flushbuffer loading_bfr.
- ld_bfr  input  32  flushbuffer window, MSB = next bit.
- bitpos  output  POS_W  total bits consumed since reset (mod 2^POS_W).
- err  output  1  sticky: illegal req_n or handshake timeout.

Behaviour:
- Reset (rst=1 at posedge) sets every output to 0. It also sets state=INIT, the timeout counter to 0 and the latched n to 0.
- Reset asserted in any state, including mid-flush, aborts immediately. No rsp_valid or flush_valid pulse follows.
- States:
  - INIT: pulse flush_valid with flush_n=0 for exactly one cycle, then go to WAIT_LOAD with prime flag set.
  - IDLE: req_ready=1. On req_valid, latch n and peek, drop req_ready, and choose the next state:
    - peek=1 -> RESP.
    - n=0 -> RESP.
    - otherwise -> CONSUME.
  - RESP: drive rsp_valid=1 for one cycle, then return to IDLE.
  - CONSUME: drive rsp_valid=1 and rsp_bits from the current ld_bfr. In the same cycle drive flush_valid=1 and flush_n=n. Add bitpos += n. Go to WAIT_LOAD.
  - WAIT_LOAD: wait for flush_loading=1, then go to WAIT_FILL.
  - WAIT_FILL: wait for flush_loading=0, then go to IDLE and clear the prime flag.
- rsp_bits arithmetic:
  - rsp_bits = ld_bfr >> (32 - n), computed with a 6-bit shift amount.
  - n=32 gives a shift of 0, so the whole window is returned.
  - n=0 gives rsp_bits=0, no flush, no bitpos change.
- Illegal req_n (33..63): set err, clamp n to 32, then proceed normally.
- Latency:
  - Peek: request accepted at cycle t, rsp_valid at t+1.
  - Get: rsp_valid and flush_valid at t+1; req_ready stays low until the cycle after flush_loading falls.
- req_valid while req_ready=0 is ignored; the client holds its request.
- Timeout:
  - The counter resets on every entry to WAIT_LOAD or WAIT_FILL.
  - When it reaches TIMEOUT, set err and go to IDLE; flushbuffer state is then undefined.
  - In INIT-prime mode a timeout also sets err and goes to IDLE.
- flush_valid is never asserted for two consecutive cycles. flush_n holds its value between pulses.
- bitpos wraps modulo 2^POS_W with no flag.

Decomposition:
- Shared package mpeg_pkg:
  - state enum (INIT, IDLE, RESP, CONSUME, WAIT_LOAD, WAIT_FILL);
  - WORD_W=32;
  - MAX_GET=32.
- One natural sub-module: mpeg_showbits, a combinational left-aligned extractor (ld_bfr, n -> bits). It is reused by VLC decoders.
- The FSM, timeout counter and bitpos counter stay in mpeg_getbits.

Test Plan:
- Reset release -> flush_valid pulse with flush_n=0 at the first posedge after rst falls. Model flushbuffer raises loading for 3 cycles -> req_ready=1 one cycle after loading falls; bitpos=0.
- ld_bfr=0x000001B3, get n=32 -> rsp_bits=0x000001B3, flush_n=32, bitpos=32.
- ld_bfr=0x47000000, peek n=8 -> rsp_bits=0x00000047 at t+1, no flush_valid, bitpos unchanged, req_ready=1 at t+2.
- ld_bfr=0xABCDE000, get n=12 -> rsp_bits=0x00000ABC, flush_n=12 single-cycle pulse, req_ready low until loading falls; then get n=0 -> rsp_bits=0, no flush.
- req_n=40 with ld_bfr=0x12345678 -> err=1 (sticky), rsp_bits=0x12345678, flush_n=32.
- flush_loading held 0 after a get with TIMEOUT=8 -> err=1 after 8 cycles, return to IDLE. Separately, rst asserted during WAIT_FILL -> all outputs 0 next cycle, then INIT re-primes with flush_n=0.
